// File: rtl/morse_text_fifo_if.sv
// Capture-side strobes and the byte read port of morse_text_fifo, bundled as one interface.
// master drives capture/consumer inputs; slave is the FIFO itself.
`ifndef MORSE_LEN_W
`define MORSE_LEN_W 3
`endif
`ifndef MAX_MORSE_LEN
`define MAX_MORSE_LEN 5
`endif

interface morse_text_fifo_if #(
  parameter int unsigned LEN_W   = `MORSE_LEN_W,
  parameter int unsigned MAX_LEN = `MAX_MORSE_LEN,
  parameter int unsigned DEPTH   = 16
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic               ce;
  logic               cap_ceo;
  logic [LEN_W-1:0]   len;
  logic [MAX_LEN-1:0] dits_dahs;
  logic               error;
  logic               char_end;
  logic               word_end;
  logic [7:0]         out_data;
  logic               out_valid;
  logic               out_ready;
  logic [CNT_W-1:0]   count;
  logic               overflow;
  logic               clr_ovf;

  modport master (
    output ce, cap_ceo, len, dits_dahs, error, char_end, word_end, out_ready, clr_ovf,
    input  out_data, out_valid, count, overflow
  );

  modport slave (
    input  ce, cap_ceo, len, dits_dahs, error, char_end, word_end, out_ready, clr_ovf,
    output out_data, out_valid, count, overflow
  );
endinterface

// File: rtl/morse_text_fifo.sv
// Decodes captured Morse characters to ASCII and queues them in a first-word-fall-through FIFO
// with a valid/ready read port and a sticky overflow flag.
`ifndef MORSE_LEN_W
`define MORSE_LEN_W 3
`endif
`ifndef MAX_MORSE_LEN
`define MAX_MORSE_LEN 5
`endif

module morse_text_fifo #(
  parameter int unsigned LEN_W   = `MORSE_LEN_W,
  parameter int unsigned MAX_LEN = `MAX_MORSE_LEN,
  parameter int unsigned DEPTH   = 16
) (
  input logic               clk,
  input logic               rst,
  morse_text_fifo_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             suppress_q, suppress_d;
  logic             cand_valid, full, pop, push;
  logic [7:0]       cand_byte;

  // Pattern is MSB-first within len bits: dit = 0, dah = 1.
  function automatic logic [7:0] decode(input logic [LEN_W-1:0] l, input logic [MAX_LEN-1:0] p);
    logic [7:0] c;
    c = 8'h3F;
    case (int'(l))
      1: c = p[0] ? "T" : "E";
      2: begin
        case (p[1:0])
          2'b00:   c = "I";
          2'b01:   c = "A";
          2'b10:   c = "N";
          default: c = "M";
        endcase
      end
      3: begin
        case (p[2:0])
          3'b000:  c = "S";
          3'b001:  c = "U";
          3'b010:  c = "R";
          3'b011:  c = "W";
          3'b100:  c = "D";
          3'b101:  c = "K";
          3'b110:  c = "G";
          default: c = "O";
        endcase
      end
      4: begin
        case (p[3:0])
          4'b0000: c = "H";
          4'b0001: c = "V";
          4'b0010: c = "F";
          4'b0100: c = "L";
          4'b0110: c = "P";
          4'b0111: c = "J";
          4'b1000: c = "B";
          4'b1001: c = "X";
          4'b1010: c = "C";
          4'b1011: c = "Y";
          4'b1100: c = "Z";
          4'b1101: c = "Q";
          default: c = 8'h3F;
        endcase
      end
      5: begin
        case (p[4:0])
          5'b11111: c = "0";
          5'b01111: c = "1";
          5'b00111: c = "2";
          5'b00011: c = "3";
          5'b00001: c = "4";
          5'b00000: c = "5";
          5'b10000: c = "6";
          5'b11000: c = "7";
          5'b11100: c = "8";
          5'b11110: c = "9";
          default:  c = 8'h3F;
        endcase
      end
      default: c = 8'h3F;
    endcase
    return c;
  endfunction

  always_comb begin
    cand_valid = 1'b0;
    cand_byte  = 8'h3F;
    if (bus.ce && bus.cap_ceo) begin
      if (bus.error) begin
        cand_valid = 1'b1;
      end else if (bus.word_end) begin
        cand_valid = ~suppress_q;
        cand_byte  = 8'h20;
      end else if (bus.char_end) begin
        cand_valid = 1'b1;
        cand_byte  = decode(bus.len, bus.dits_dahs);
      end
    end
  end

  assign full = (count_q == CNT_W'(DEPTH));
  assign pop  = (count_q != '0) & bus.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push = cand_valid & (~full | pop);

  always_comb begin
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (cand_valid && full && !pop) begin
      overflow_d = 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_d = 1'b0;
    end
    suppress_d = push ? (cand_byte == 8'h20) : suppress_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      suppress_q <= 1'b1;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      suppress_q <= suppress_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= cand_byte;
    end
  end

  assign bus.out_data  = mem[rd_ptr_q];
  assign bus.out_valid = (count_q != '0);
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
endmodule
